// File: rtl/matmul_flags_pkg.sv
// rtl/matmul_flags_pkg.sv - register map and field constants for the matmul flag controller
package matmul_flags_pkg;

  localparam logic [1:0] ADDR_FLAGS  = 2'd0;
  localparam logic [1:0] ADDR_MASK   = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int CTRL_STICKY = 0;
  localparam int CTRL_IRQ_EN = 1;

  localparam int STATUS_POP_LSB = 0;
  localparam int STATUS_POP_W   = 8;
  localparam int STATUS_EVT_LSB = 8;
  localparam int STATUS_EVT_W   = 8;

endpackage

// File: rtl/matmul_flags_ctrl_popcount.sv
// rtl/matmul_flags_ctrl_popcount.sv - combinational population count of the flag vector
module flags_popcount #(
  parameter int N = 4,
  parameter int W = $clog2(N + 1)
) (
  input  logic [N-1:0] vec_i,
  output logic [W-1:0] cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < N; i++) begin
      cnt_o = cnt_o + W'(vec_i[i]);
    end
  end

endmodule

// File: rtl/matmul_flags_ctrl.sv
// rtl/matmul_flags_ctrl.sv - sticky/snapshot capture of matmul cell flags with mask, W1C,
// saturating event counter and level interrupt
module matmul_flags_ctrl
  import matmul_flags_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH  = 64,
  parameter int MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
  parameter int NUM_FLAGS  = MAX_DIM * MAX_DIM,
  parameter int EVT_W      = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flags_valid_i,
  input  logic [NUM_FLAGS-1:0] flags_i,
  input  logic                 bus_sel_i,
  input  logic                 bus_we_i,
  input  logic [1:0]           bus_addr_i,
  input  logic [BUS_WIDTH-1:0] bus_wdata_i,
  output logic [BUS_WIDTH-1:0] bus_rdata_o,
  output logic                 bus_rvalid_o,
  output logic                 irq_o
);

  localparam int POP_W = $clog2(NUM_FLAGS + 1);

  if (NUM_FLAGS > BUS_WIDTH) begin : g_chk_flags
    $error("NUM_FLAGS must not exceed BUS_WIDTH");
  end
  if (EVT_W > STATUS_EVT_W) begin : g_chk_evt
    $error("EVT_W does not fit the STATUS event field");
  end

  logic [NUM_FLAGS-1:0] flags_q, flags_d;
  logic [NUM_FLAGS-1:0] mask_q, mask_d;
  logic [1:0]           ctrl_q, ctrl_d;
  logic [EVT_W-1:0]     evt_q, evt_d;
  logic                 irq_d;
  logic [BUS_WIDTH-1:0] rdata_q, rd_word;
  logic                 rvalid_q;
  logic [POP_W-1:0]     pop;
  logic                 wr_en, rd_en;
  logic                 unused_wdata;

  assign wr_en        = bus_sel_i & bus_we_i;
  assign rd_en        = bus_sel_i & ~bus_we_i;
  assign unused_wdata = ^bus_wdata_i;

  flags_popcount #(.N(NUM_FLAGS), .W(POP_W)) u_popcount (
    .vec_i (flags_q),
    .cnt_o (pop)
  );

  always_comb begin
    flags_d = flags_q;
    mask_d  = mask_q;
    ctrl_d  = ctrl_q;
    evt_d   = evt_q;
    if (wr_en) begin
      case (bus_addr_i)
        ADDR_FLAGS: flags_d = flags_q & ~bus_wdata_i[NUM_FLAGS-1:0];
        ADDR_MASK:  mask_d  = bus_wdata_i[NUM_FLAGS-1:0];
        ADDR_CTRL:  ctrl_d  = bus_wdata_i[1:0];
        default:    ;
      endcase
    end
    // Hardware capture is applied after the W1C so a same-cycle set always survives.
    if (flags_valid_i) begin
      flags_d = ctrl_q[CTRL_STICKY] ? (flags_d | flags_i) : flags_i;
    end
    if (wr_en && bus_addr_i == ADDR_STATUS) begin
      evt_d = '0;
    end else if (flags_valid_i && (|flags_i) && evt_q != {EVT_W{1'b1}}) begin
      evt_d = evt_q + EVT_W'(1);
    end
    irq_d = ctrl_d[CTRL_IRQ_EN] & (|(flags_d & mask_d));
  end

  always_comb begin
    rd_word = '0;
    case (bus_addr_i)
      ADDR_FLAGS: rd_word[NUM_FLAGS-1:0] = flags_q;
      ADDR_MASK:  rd_word[NUM_FLAGS-1:0] = mask_q;
      ADDR_CTRL:  rd_word[1:0]           = ctrl_q;
      default: begin
        rd_word[STATUS_POP_LSB +: STATUS_POP_W] = STATUS_POP_W'(pop);
        rd_word[STATUS_EVT_LSB +: EVT_W]        = evt_q;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flags_q  <= '0;
      mask_q   <= '1;
      ctrl_q   <= 2'b01;
      evt_q    <= '0;
      irq_o    <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      flags_q  <= flags_d;
      mask_q   <= mask_d;
      ctrl_q   <= ctrl_d;
      evt_q    <= evt_d;
      irq_o    <= irq_d;
      rvalid_q <= rd_en;
      if (rd_en) begin
        rdata_q <= rd_word;
      end
    end
  end

  assign bus_rdata_o  = rdata_q;
  assign bus_rvalid_o = rvalid_q;

endmodule

// File: tb/tb_matmul_flags_ctrl.sv
// tb/tb_matmul_flags_ctrl.sv - table-driven and scoreboard-checked bench for matmul_flags_ctrl
module tb_matmul_flags_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flags_valid_i = 1'b0;
  logic [3:0]  flags_i = '0;
  logic        bus_sel_i = 1'b0;
  logic        bus_we_i = 1'b0;
  logic [1:0]  bus_addr_i = '0;
  logic [63:0] bus_wdata_i = '0;
  logic [63:0] bus_rdata_o;
  logic        bus_rvalid_o;
  logic        irq_o;

  matmul_flags_ctrl dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .flags_valid_i (flags_valid_i),
    .flags_i       (flags_i),
    .bus_sel_i     (bus_sel_i),
    .bus_we_i      (bus_we_i),
    .bus_addr_i    (bus_addr_i),
    .bus_wdata_i   (bus_wdata_i),
    .bus_rdata_o   (bus_rdata_o),
    .bus_rvalid_o  (bus_rvalid_o),
    .irq_o         (irq_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]  addr;
    logic [63:0] data;
  } rd_exp_t;

  typedef struct {
    logic        sel;
    logic [1:0]  addr;
    logic [63:0] wdata;
    logic        fv;
    logic [3:0]  fl;
    logic [3:0]  exp_flags;
    logic [15:0] exp_status;
  } vec_t;

  rd_exp_t exp_q[$];
  vec_t    vecs[13];
  int      checks = 0;
  int      passes = 0;
  logic    pend = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Read-data scoreboard and one-cycle rvalid latency check.
  always @(negedge clk_i) begin
    rd_exp_t e;
    if (pend || bus_rvalid_o) chk("rvalid_timing", {63'd0, bus_rvalid_o}, {63'd0, pend});
    if (bus_rvalid_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL sb_unexpected: got rdata %h expected no read", bus_rdata_o);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("rdata_addr%0d", e.addr), bus_rdata_o, e.data);
      end
    end
    pend = bus_sel_i & ~bus_we_i & rst_ni;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [63:0] data);
    bus_sel_i = 1'b1; bus_we_i = 1'b1; bus_addr_i = addr; bus_wdata_i = data;
    tick();
    bus_sel_i = 1'b0; bus_we_i = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] addr, input logic [63:0] exp);
    rd_exp_t e;
    e.addr = addr;
    e.data = exp;
    exp_q.push_back(e);
    bus_sel_i = 1'b1; bus_we_i = 1'b0; bus_addr_i = addr;
    tick();
    bus_sel_i = 1'b0;
  endtask

  task automatic capture(input logic [3:0] fl);
    flags_valid_i = 1'b1; flags_i = fl;
    tick();
    flags_valid_i = 1'b0; flags_i = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b0, 2'd0, 64'h0, 1'b1, 4'b0001, 4'b0001, 16'h0101};
    vecs[1]  = '{1'b0, 2'd0, 64'h0, 1'b1, 4'b0100, 4'b0101, 16'h0202};
    vecs[2]  = '{1'b0, 2'd0, 64'h0, 1'b1, 4'b0000, 4'b0101, 16'h0202};
    vecs[3]  = '{1'b1, 2'd0, 64'h5, 1'b1, 4'b0001, 4'b0001, 16'h0301};
    vecs[4]  = '{1'b1, 2'd2, 64'h0, 1'b0, 4'b0000, 4'b0001, 16'h0301};
    vecs[5]  = '{1'b0, 2'd0, 64'h0, 1'b1, 4'b1111, 4'b1111, 16'h0404};
    vecs[6]  = '{1'b0, 2'd0, 64'h0, 1'b1, 4'b0010, 4'b0010, 16'h0501};
    vecs[7]  = '{1'b1, 2'd0, 64'h2, 1'b1, 4'b1000, 4'b1000, 16'h0601};
    vecs[8]  = '{1'b1, 2'd0, 64'hFFFF_0000_0000_0008, 1'b0, 4'b0000, 4'b0000, 16'h0600};
    vecs[9]  = '{1'b1, 2'd3, 64'hFFFF, 1'b0, 4'b0000, 4'b0000, 16'h0000};
    vecs[10] = '{1'b0, 2'd0, 64'h0, 1'b1, 4'b0110, 4'b0110, 16'h0102};
    vecs[11] = '{1'b1, 2'd2, 64'h1, 1'b0, 4'b0000, 4'b0110, 16'h0102};
    vecs[12] = '{1'b1, 2'd3, 64'h0, 1'b1, 4'b0001, 4'b0111, 16'h0003};

    // Reset state
    repeat (3) tick();
    chk("reset_rdata", bus_rdata_o, 64'h0);
    chk("reset_rvalid", {63'd0, bus_rvalid_o}, 64'h0);
    chk("reset_irq", {63'd0, irq_o}, 64'h0);
    rst_ni = 1'b1;
    tick();
    bus_read(2'd0, 64'h0);
    bus_read(2'd1, 64'hF);
    bus_read(2'd2, 64'h1);
    bus_read(2'd3, 64'h0);

    // Capture / W1C / snapshot table
    foreach (vecs[i]) begin
      bus_sel_i = vecs[i].sel; bus_we_i = vecs[i].sel;
      bus_addr_i = vecs[i].addr; bus_wdata_i = vecs[i].wdata;
      flags_valid_i = vecs[i].fv; flags_i = vecs[i].fl;
      tick();
      bus_sel_i = 1'b0; bus_we_i = 1'b0; flags_valid_i = 1'b0; flags_i = '0;
      bus_read(2'd0, {60'd0, vecs[i].exp_flags});
      bus_read(2'd3, {48'd0, vecs[i].exp_status});
    end

    // Interrupt sequences
    bus_write(2'd0, 64'hF);
    bus_write(2'd1, 64'h8);
    bus_write(2'd2, 64'h3);
    chk("irq_idle", {63'd0, irq_o}, 64'h0);
    capture(4'b0001);
    chk("irq_masked", {63'd0, irq_o}, 64'h0);
    tick();
    chk("irq_masked_hold", {63'd0, irq_o}, 64'h0);
    capture(4'b1000);
    chk("irq_set", {63'd0, irq_o}, 64'h1);
    bus_write(2'd0, 64'h8);
    chk("irq_w1c_drop", {63'd0, irq_o}, 64'h0);
    capture(4'b1000);
    chk("irq_set2", {63'd0, irq_o}, 64'h1);
    bus_write(2'd2, 64'h1);
    chk("irq_en_drop", {63'd0, irq_o}, 64'h0);
    bus_write(2'd2, 64'h3);
    chk("irq_en_set", {63'd0, irq_o}, 64'h1);
    bus_write(2'd1, 64'h0);
    chk("irq_mask_drop", {63'd0, irq_o}, 64'h0);
    bus_write(2'd1, 64'hF);
    chk("irq_mask_set", {63'd0, irq_o}, 64'h1);
    bus_read(2'd0, 64'h9);

    // Event counter saturation and clear-wins collision
    bus_write(2'd3, 64'h0);
    flags_valid_i = 1'b1; flags_i = 4'b0001;
    repeat (260) tick();
    flags_valid_i = 1'b0; flags_i = '0;
    bus_read(2'd3, 64'hFF02);
    bus_sel_i = 1'b1; bus_we_i = 1'b1; bus_addr_i = 2'd3; bus_wdata_i = 64'h0;
    flags_valid_i = 1'b1; flags_i = 4'b0001;
    tick();
    bus_sel_i = 1'b0; bus_we_i = 1'b0; flags_valid_i = 1'b0; flags_i = '0;
    bus_read(2'd3, 64'h0002);
    tick();
    chk("irq_pre_reset", {63'd0, irq_o}, 64'h1);

    // Reset in the middle of a read
    bus_sel_i = 1'b1; bus_we_i = 1'b0; bus_addr_i = 2'd0;
    #2 rst_ni = 1'b0;
    @(posedge clk_i); #1;
    bus_sel_i = 1'b0;
    chk("midrst_rvalid", {63'd0, bus_rvalid_o}, 64'h0);
    chk("midrst_rdata", bus_rdata_o, 64'h0);
    chk("midrst_irq", {63'd0, irq_o}, 64'h0);
    tick();
    rst_ni = 1'b1;
    tick();
    bus_read(2'd0, 64'h0);
    bus_read(2'd1, 64'hF);
    bus_read(2'd2, 64'h1);
    bus_read(2'd3, 64'h0);

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL sb_drain: got %0d pending reads expected 0", exp_q.size());
    end
    tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
